// File: rtl/alu_operand_loader_if.sv
// Byte-stream input and ALU-operand transaction output of alu_operand_loader.
// The loader connects to the slave modport; the byte source/ALU side uses master.
interface alu_operand_loader_if #(
    parameter int G_N_BIT = 7,
    parameter int G_N_OP  = 4
);
    logic [G_N_BIT:0]  i_data;
    logic              i_valid;
    logic              o_ready;
    logic [G_N_BIT:0]  o_s1;
    logic [G_N_BIT:0]  o_s2;
    logic [G_N_OP-1:0] o_op;
    logic              o_valid;
    logic              i_ready;
    logic [7:0]        o_count;

    modport master (
        output i_data, i_valid, i_ready,
        input  o_ready, o_s1, o_s2, o_op, o_valid, o_count
    );

    modport slave (
        input  i_data, i_valid, i_ready,
        output o_ready, o_s1, o_s2, o_op, o_valid, o_count
    );
endinterface

// File: rtl/alu_operand_loader.sv
// Collects operand 1, operand 2 and opcode from a narrow valid/ready byte stream and issues
// them as one registered ALU transaction. Optional macro: ALU_LOADER_OVERLAP_EN.
module alu_operand_loader #(
    parameter int G_N_BIT = 7,
    parameter int G_N_OP  = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_clr,
    alu_operand_loader_if.slave  bus
);

    typedef enum logic [1:0] {S_A, S_B, S_OP, S_ISSUE} state_t;

    state_t            state;
    logic [G_N_BIT:0]  s1_q;
    logic [G_N_BIT:0]  s2_q;
    logic [G_N_OP-1:0] op_q;
    logic              valid_q;
    logic [7:0]        count_q;
    logic              accept;
    logic              handshake;

    // NOTE: o_ready is gated by i_rst directly so it reads 0 during reset and 1 the moment
    // reset is released, without waiting for a clock edge.
`ifdef ALU_LOADER_OVERLAP_EN
    assign bus.o_ready = ~i_rst & ((state != S_ISSUE) | bus.i_ready);
`else
    assign bus.o_ready = ~i_rst & (state != S_ISSUE);
`endif

    assign accept    = bus.i_valid & bus.o_ready;
    assign handshake = valid_q & bus.i_ready;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= S_A;
            s1_q    <= '0;
            s2_q    <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
            count_q <= 8'd0;
        end else if (i_clr) begin
            // Abort drops the partial or pending triple; the counter is left alone.
            state   <= S_A;
            s1_q    <= '0;
            s2_q    <= '0;
            op_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                S_A: if (accept) begin
                    s1_q  <= bus.i_data;
                    state <= S_B;
                end
                S_B: if (accept) begin
                    s2_q  <= bus.i_data;
                    state <= S_OP;
                end
                S_OP: if (accept) begin
                    op_q    <= bus.i_data[G_N_OP-1:0];
                    valid_q <= 1'b1;
                    state   <= S_ISSUE;
                end
                S_ISSUE: if (handshake) begin
                    valid_q <= 1'b0;
                    count_q <= count_q + 8'd1;
`ifdef ALU_LOADER_OVERLAP_EN
                    // The byte offered on the handshake edge is the next operand 1.
                    if (accept) begin
                        s1_q  <= bus.i_data;
                        state <= S_B;
                    end else begin
                        state <= S_A;
                    end
`else
                    state <= S_A;
`endif
                end
                default: state <= S_A;
            endcase
        end
    end

    assign bus.o_s1    = s1_q;
    assign bus.o_s2    = s2_q;
    assign bus.o_op    = op_q;
    assign bus.o_valid = valid_q;
    assign bus.o_count = count_q;

endmodule

// File: doc/alu_operand_loader.md
# alu_operand_loader

Upstream feeder for the ALU datapath stage. Collects operand 1, operand 2 and an opcode as three successive bytes from a narrow valid/ready input stream. Holds them stable on registered outputs wired straight to the ALU operand inputs, and issues one valid/ready transaction per triple. Lets the pad-limited top level drive both ALU operands and the operation from a single 8-bit input bus.

## Interface
- G_N_BIT, 7, MSB index of operand and data buses (width = G_N_BIT+1); matches the ALU's G_N_BIT
- G_N_OP, 4, opcode width in bits; 1 ≤ G_N_OP ≤ G_N_BIT+1
- i_clk  in  1  clock; all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_clr  in  1  synchronous abort; discards partial or pending transaction
- i_data  in  G_N_BIT+1  input byte (operand 1, operand 2, or opcode, by state)
- i_valid  in  1  i_data valid
- o_ready  out  1  loader accepts i_data this cycle
- o_s1  out  G_N_BIT+1  operand 1 to ALU i_s1
- o_s2  out  G_N_BIT+1  operand 2 to ALU i_s2
- o_op  out  G_N_OP  opcode to ALU
- o_valid  out  1  o_s1/o_s2/o_op form a complete transaction
- i_ready  in  1  downstream consumes the transaction
- o_count  out  8  issued-transaction counter, wraps 255→0

## Operation
- Accept = i_valid & o_ready at a rising edge.
- States:
  - S_A (load o_s1)
  - S_B (load o_s2)
  - S_OP (load o_op = i_data[G_N_OP-1:0]; upper bits ignored)
  - S_ISSUE
- Transitions:
  - S_A→S_B, S_B→S_OP, S_OP→S_ISSUE, each on accept only; no accept means hold state.
  - S_ISSUE→S_A when i_ready=1.
- o_ready = 1 in S_A/S_B/S_OP, 0 in S_ISSUE (base build). Forced 0 while i_rst=1.
- o_valid = 1 exactly in S_ISSUE; registered, not combinational.
- o_s1/o_s2/o_op change only on their own accept or on reset/clear. They are stable for the whole S_ISSUE interval, including while i_ready=0.
- o_count increments by 1 on each handshake (o_valid & i_ready). 8-bit unsigned, wraps 255→0.
- i_clr=1 (takes priority over everything except i_rst):
  - next state S_A
  - o_s1, o_s2, o_op ← 0; o_valid ← 0
  - any same-cycle accept or handshake ignored; o_count unchanged
- i_valid=1 without o_ready: data not taken. The upstream must hold it (standard valid/ready).

## Timing
- Reset values: state S_A, o_s1=0, o_s2=0, o_op=0, o_valid=0, o_count=0. o_ready=0 during reset, then 1 in the first cycle after release.
- Reset mid-transaction (any state) drops it immediately and asynchronously; no handshake is counted.
- Best-case latency: opcode accepted at edge N, o_valid=1 after edge N. With i_ready=1, handshake at edge N+1 and o_valid=0 after it.
- Best-case base-build throughput: one transaction per 4 cycles (3 load + 1 issue).
- i_ready while o_valid=0 has no effect.

## Configuration
- Macro ALU_LOADER_OVERLAP_EN.
- Defined:
  - In S_ISSUE, o_ready = i_ready.
  - On a cycle with handshake and i_valid=1, the byte loads o_s1 and next state is S_B (skips S_A).
  - o_count still increments.
  - Best-case throughput: one transaction per 3 cycles.
  - o_ready then depends combinationally on i_ready.
- Undefined: o_ready=0 throughout S_ISSUE, as in Operation; no combinational path i_ready→o_ready.

## Test plan
- Reset then stream 0x12, 0x34, 0xA5 with i_valid=1 and i_ready=1 → o_s1=0x12, o_s2=0x34, o_op=0x5, o_valid high for exactly one cycle, o_count=1.
- Same stream with i_ready=0 for 5 cycles → o_valid and outputs held unchanged, o_ready=0, extra i_valid bytes not taken. Then i_ready=1 → single handshake, o_count=1.
- Gaps: i_valid toggles 1,0,0,1,0,1 carrying 0x01, 0x02, 0x03 → state advances only on accepts, result o_s1=0x01, o_s2=0x02, o_op=0x3.
- i_clr pulse after the second byte, then bytes 0x0F, 0xF0, 0x07 → o_s1=0x0F, o_s2=0xF0, o_op=0x7; o_count not incremented by the aborted transaction.
- 256 back-to-back transactions → o_count wraps to 0. Async i_rst in S_OP → all outputs zero without a clock edge.
- With ALU_LOADER_OVERLAP_EN, continuous i_valid and i_ready → o_valid once every 3 cycles, first byte of the next triple loaded on the handshake edge.
